// File: rtl/am_accuracy_tally.sv
// am_accuracy_tally: scores class decisions against labels during a test run
// and keeps global and per-class counts for accuracy readout.
module am_accuracy_tally #(
  parameter int NUM_CLASSES = 26,
  parameter int TOTAL_CTR_W = 16,
  parameter int CLASS_CTR_W = 12
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   en,
  input  logic                   clear,
  input  logic                   start_tally,
  input  logic                   tallying_accuracy,
  input  logic [4:0]             class_inference,
  input  logic [4:0]             true_label,
  input  logic                   testing_dataset_finished,
  input  logic [4:0]             rd_class,
  output logic [TOTAL_CTR_W-1:0] total_samples,
  output logic [TOTAL_CTR_W-1:0] total_correct,
  output logic [TOTAL_CTR_W-1:0] invalid_labels,
  output logic                   last_correct,
  output logic                   tally_valid,
  output logic                   results_ready,
  output logic [CLASS_CTR_W-1:0] rd_class_total,
  output logic [CLASS_CTR_W-1:0] rd_class_correct
);

  typedef enum logic [1:0] {
    IDLE,
    TALLY,
    DONE
  } state_t;

  state_t state;

  logic [CLASS_CTR_W-1:0] class_total   [NUM_CLASSES];
  logic [CLASS_CTR_W-1:0] class_correct [NUM_CLASSES];

  logic                   count;
  logic                   label_ok;
  logic                   hit;
  logic [CLASS_CTR_W-1:0] sel_total;
  logic [CLASS_CTR_W-1:0] sel_correct;

  assign count    = (state == TALLY) && tallying_accuracy;
  assign label_ok = int'(true_label) < NUM_CLASSES;
  assign hit      = label_ok && (class_inference == true_label);

  function automatic logic [TOTAL_CTR_W-1:0] t_inc(
    input logic [TOTAL_CTR_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CLASS_CTR_W-1:0] c_inc(
    input logic [CLASS_CTR_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  // Readout select mux; out-of-range classes match nothing and read 0
  always_comb begin
    sel_total   = '0;
    sel_correct = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (rd_class == 5'(i)) begin
        sel_total   = class_total[i];
        sel_correct = class_correct[i];
      end
    end
  end

  // FSM, global counters and per-query result flags
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state          <= IDLE;
      total_samples  <= '0;
      total_correct  <= '0;
      invalid_labels <= '0;
      last_correct   <= 1'b0;
      tally_valid    <= 1'b0;
      results_ready  <= 1'b0;
    end else if (en) begin
      if (clear) begin
        state          <= IDLE;
        total_samples  <= '0;
        total_correct  <= '0;
        invalid_labels <= '0;
        last_correct   <= 1'b0;
        tally_valid    <= 1'b0;
        results_ready  <= 1'b0;
      end else begin
        tally_valid <= count;
        if (count) begin
          total_samples <= t_inc(total_samples);
          last_correct  <= hit;
          if (hit)
            total_correct <= t_inc(total_correct);
          if (!label_ok)
            invalid_labels <= t_inc(invalid_labels);
        end
        unique case (state)
          IDLE: begin
            results_ready <= 1'b0;
            if (start_tally)
              state <= TALLY;
          end
          TALLY: begin
            if (testing_dataset_finished) begin
              state         <= DONE;
              results_ready <= 1'b1;
            end
          end
          DONE: results_ready <= 1'b1;
          default: begin
            state         <= IDLE;
            results_ready <= 1'b0;
          end
        endcase
      end
    end
  end

  // Per-class counters, indexed by the ground-truth label
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        class_total[i]   <= '0;
        class_correct[i] <= '0;
      end
    end else if (en) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        if (clear) begin
          class_total[i]   <= '0;
          class_correct[i] <= '0;
        end else if (count && true_label == 5'(i)) begin
          class_total[i] <= c_inc(class_total[i]);
          if (hit)
            class_correct[i] <= c_inc(class_correct[i]);
        end
      end
    end
  end

  // Registered per-class readout
  always_ff @(posedge clk) begin
    if (!nrst) begin
      rd_class_total   <= '0;
      rd_class_correct <= '0;
    end else if (en) begin
      if (clear) begin
        rd_class_total   <= '0;
        rd_class_correct <= '0;
      end else begin
        rd_class_total   <= sel_total;
        rd_class_correct <= sel_correct;
      end
    end
  end

endmodule

// File: tb/tb_am_accuracy_tally.sv
// tb_am_accuracy_tally: directed vectors, queue scoreboard on tally_valid,
// plus a narrow-counter instance for saturation.
module tb_am_accuracy_tally;

  logic       clk = 1'b0;
  logic       nrst;
  logic       en;
  logic       clear;
  logic       start_tally;
  logic       tallying_accuracy;
  logic [4:0] class_inference;
  logic [4:0] true_label;
  logic       testing_dataset_finished;
  logic [4:0] rd_class;

  logic [15:0] total_samples, total_correct, invalid_labels;
  logic        last_correct, tally_valid, results_ready;
  logic [11:0] rd_class_total, rd_class_correct;

  logic [3:0] n_samples, n_correct, n_invalid;
  logic       n_last, n_valid, n_ready;
  logic [3:0] n_rd_total, n_rd_correct;

  always #5 clk = ~clk;

  am_accuracy_tally dut (
    .clk(clk), .nrst(nrst), .en(en), .clear(clear),
    .start_tally(start_tally),
    .tallying_accuracy(tallying_accuracy),
    .class_inference(class_inference),
    .true_label(true_label),
    .testing_dataset_finished(testing_dataset_finished),
    .rd_class(rd_class),
    .total_samples(total_samples),
    .total_correct(total_correct),
    .invalid_labels(invalid_labels),
    .last_correct(last_correct),
    .tally_valid(tally_valid),
    .results_ready(results_ready),
    .rd_class_total(rd_class_total),
    .rd_class_correct(rd_class_correct)
  );

  am_accuracy_tally #(
    .NUM_CLASSES(26), .TOTAL_CTR_W(4), .CLASS_CTR_W(4)
  ) dut_n (
    .clk(clk), .nrst(nrst), .en(en), .clear(clear),
    .start_tally(start_tally),
    .tallying_accuracy(tallying_accuracy),
    .class_inference(class_inference),
    .true_label(true_label),
    .testing_dataset_finished(testing_dataset_finished),
    .rd_class(rd_class),
    .total_samples(n_samples),
    .total_correct(n_correct),
    .invalid_labels(n_invalid),
    .last_correct(n_last),
    .tally_valid(n_valid),
    .results_ready(n_ready),
    .rd_class_total(n_rd_total),
    .rd_class_correct(n_rd_correct)
  );

  typedef struct {
    int samples;
    int correct;
    int invalid;
    int lc;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // bench-side model
  int m_state;
  int m_samples, m_correct, m_invalid;
  int m_ctot[26];
  int m_ccor[26];

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  task automatic model_clear();
    m_state   = 0;
    m_samples = 0;
    m_correct = 0;
    m_invalid = 0;
    for (int i = 0; i < 26; i++) begin
      m_ctot[i] = 0;
      m_ccor[i] = 0;
    end
  endtask

  // monitor: every tally_valid pulse must match a queued expectation
  always @(negedge clk) begin
    if (tally_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_tally_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("total_samples", int'(total_samples), e.samples);
        chk("total_correct", int'(total_correct), e.correct);
        chk("invalid_labels", int'(invalid_labels), e.invalid);
        chk("last_correct", int'(last_correct), e.lc);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    model_clear();
  endtask

  task automatic start();
    start_tally = 1'b1;
    tick();
    start_tally = 1'b0;
    if (m_state == 0) m_state = 1;
  endtask

  task automatic strobe(input int inf, input int lab, input bit fin);
    exp_t e;
    tallying_accuracy        = 1'b1;
    class_inference          = 5'(inf);
    true_label               = 5'(lab);
    testing_dataset_finished = fin;
    if (m_state == 1) begin
      m_samples = (m_samples < 65535) ? m_samples + 1 : m_samples;
      e.lc = 0;
      if (lab < 26) begin
        m_ctot[lab]++;
        if (inf == lab) begin
          m_ccor[lab]++;
          m_correct++;
          e.lc = 1;
        end
      end else begin
        m_invalid++;
      end
      e.samples = m_samples;
      e.correct = m_correct;
      e.invalid = m_invalid;
      exp_q.push_back(e);
      if (fin) m_state = 2;
    end
    tick();
    tallying_accuracy        = 1'b0;
    testing_dataset_finished = 1'b0;
  endtask

  task automatic check_rd(input int c, input int et, input int ec);
    rd_class = 5'(c);
    tick();
    chk($sformatf("rd_total[%0d]", c), int'(rd_class_total), et);
    chk($sformatf("rd_correct[%0d]", c), int'(rd_class_correct), ec);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    nrst = 1'b0;
    en = 1'b1;
    clear = 1'b0;
    start_tally = 1'b0;
    tallying_accuracy = 1'b0;
    class_inference = '0;
    true_label = '0;
    testing_dataset_finished = 1'b0;
    rd_class = '0;
    tick();
    tick();
    nrst = 1'b1;
    model_clear();

    chk("rst_samples", int'(total_samples), 0);
    chk("rst_correct", int'(total_correct), 0);
    chk("rst_invalid", int'(invalid_labels), 0);
    chk("rst_last", int'(last_correct), 0);
    chk("rst_valid", int'(tally_valid), 0);
    chk("rst_ready", int'(results_ready), 0);
    chk("rst_rd_total", int'(rd_class_total), 0);
    chk("rst_rd_correct", int'(rd_class_correct), 0);

    // strobe in IDLE is ignored
    strobe(2, 2, 0);
    chk("idle_strobe_valid", int'(tally_valid), 0);
    chk("idle_strobe_samples", int'(total_samples), 0);

    // basic tally, back-to-back
    start();
    strobe(3, 3, 0);
    strobe(5, 3, 0);
    strobe(25, 25, 0);
    strobe(0, 1, 0);
    tick();
    check_rd(3, 2, 1);
    check_rd(25, 1, 1);
    check_rd(1, 1, 0);

    // out-of-range label
    strobe(7, 30, 0);
    tick();
    check_rd(3, 2, 1);
    check_rd(30, 0, 0);

    // strobe together with end of dataset
    strobe(2, 2, 1);
    chk("ready_after_fin", int'(results_ready), 1);
    strobe(4, 4, 0);
    chk("done_strobe_valid", int'(tally_valid), 0);
    chk("done_samples", int'(total_samples), 6);
    start();
    strobe(4, 4, 0);
    chk("done_start_ignored", int'(tally_valid), 0);

    // en low blocks clear and strobe
    en = 1'b0;
    clear = 1'b1;
    tallying_accuracy = 1'b1;
    tick();
    tallying_accuracy = 1'b0;
    chk("en0_ready", int'(results_ready), 1);
    chk("en0_samples", int'(total_samples), 6);
    chk("en0_correct", int'(total_correct), 3);
    en = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
    chk("clr_ready", int'(results_ready), 0);
    chk("clr_samples", int'(total_samples), 0);
    chk("clr_correct", int'(total_correct), 0);
    chk("clr_invalid", int'(invalid_labels), 0);
    check_rd(3, 0, 0);
    strobe(1, 1, 0);
    chk("clr_idle_strobe", int'(tally_valid), 0);

    // saturation on the narrow instance
    start();
    for (int i = 0; i < 20; i++) strobe(0, 0, 0);
    tick();
    chk("sat_samples", int'(n_samples), 15);
    chk("sat_correct", int'(n_correct), 15);
    chk("wide_samples", int'(total_samples), 20);
    rd_class = 5'd0;
    tick();
    chk("sat_rd_total", int'(n_rd_total), 15);
    chk("sat_rd_correct", int'(n_rd_correct), 15);

    // reset mid-tally after 7 strobes
    do_reset();
    start();
    for (int i = 0; i < 7; i++) strobe(i, i, 0);
    tick();
    do_reset();
    chk("mid_rst_samples", int'(total_samples), 0);
    chk("mid_rst_correct", int'(total_correct), 0);
    chk("mid_rst_last", int'(last_correct), 0);
    chk("mid_rst_rd", int'(rd_class_total), 0);
    strobe(1, 1, 0);
    chk("mid_rst_idle_strobe", int'(tally_valid), 0);
    chk("mid_rst_idle_samples", int'(total_samples), 0);
    start();
    strobe(1, 1, 0);
    tick();
    check_rd(1, 1, 1);

    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
